eka_mem_sequencer: RTL and testbench
====================================

Name: eka_mem_sequencer

Overview:
- Shares one single-ported, variable-latency memory bus between the Eka single-cycle core's instruction-fetch and data ports.
- Sequences each instruction through fetch, optional data access, and commit.
- Drives the core's inst_valid and data_stall so the PC and register file advance exactly once per instruction.
- Sits between the core and the unified memory/cache.

Parameters:
ADDR_WIDTH, 32, width of core inst_addr (bus address is always 32 bits; inst_addr is zero-extended)
NOP_INST, 32'h0000_0013, instruction presented to the core while no fetched instruction is valid (addi x0,x0,0)
TIMEOUT_CYCLES, 0, max wait cycles for bus_ack per transaction; 0 disables the watchdog

Ports:
clk  in  1  processor clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
inst_addr  in  ADDR_WIDTH  core fetch address (PC)
instruction  out  32  instruction to core
inst_valid  out  1  instruction on `instruction` is the fetched one
data_addr  in  32  core load/store address
mem_wr_data  in  32  core store data
mem_wr  in  1  core store request (decoded from `instruction`)
mem_rd  in  1  core load request (decoded from `instruction`)
mem_rd_data  out  32  load data to core
data_stall  out  1  core must not commit
bus_req  out  1  memory request; held until bus_ack
bus_wr  out  1  1 = write, 0 = read
bus_addr  out  32  memory address
bus_wdata  out  32  memory write data
bus_ack  in  1  single-cycle completion pulse; bus_rdata valid with it
bus_rdata  in  32  memory read data
bus_err  out  1  sticky watchdog error flag

Behaviour:
- States: FETCH, DECODE, DATA, COMMIT.
- While reset=0:
  - state=FETCH; bus_req=0, bus_err=0.
  - inst_q=NOP_INST, rdata_q=0, inst_valid=0.
  - data_stall=0, timeout counter=0.
  - The first bus_req is driven on the first clk edge after reset rises.
- FETCH:
  - bus_req=1, bus_wr=0, bus_addr=zero-extended inst_addr.
  - instruction=NOP_INST, inst_valid=0, data_stall=0.
  - On bus_ack: inst_q<=bus_rdata, go to DECODE.
- DECODE:
  - instruction=inst_q, inst_valid=1, bus_req=0.
  - If mem_rd|mem_wr=0: data_stall=0. This cycle is the core's commit edge. Go to FETCH.
  - Else: data_stall=1; latch addr_q<=data_addr, wdata_q<=mem_wr_data, wr_q<=mem_wr. Go to DATA.
  - If both mem_rd and mem_wr are high, treat as a write.
- DATA:
  - bus_req=1, bus_wr=wr_q, bus_addr=addr_q, bus_wdata=wdata_q.
  - instruction=inst_q, inst_valid=1, data_stall=1.
  - Latched address guarantees stability even if the core overwrites rs1 during the stall (e.g. lw x5,0(x5)).
  - On bus_ack: if !wr_q, rdata_q<=bus_rdata. Go to COMMIT.
- COMMIT: inst_valid=1, data_stall=0, bus_req=0. Go to FETCH.
- mem_rd_data=rdata_q at all times.
- bus_ack may be asserted in the same cycle bus_req rises (zero wait state). bus_ack outside FETCH/DATA is ignored.
- Throughput:
  - Non-memory instruction: 2 cycles min (FETCH, DECODE).
  - Load/store: 4 cycles min (FETCH, DECODE, DATA, COMMIT).
  - Each bus wait cycle adds one cycle.
- bus_wdata=wdata_q in all states. bus_wr=0 outside DATA.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each cycle in FETCH or DATA without bus_ack; clears on ack and on state entry.
  - Reaching TIMEOUT_CYCLES sets bus_err (sticky until reset) and aborts the transaction.
  - FETCH abort: inst_q<=NOP_INST, go to DECODE.
  - DATA abort: rdata_q<=0, go to COMMIT.
  - The core never deadlocks.
- Asynchronous reset mid-transaction: bus_req drops immediately. The memory shares the same reset, so no stale ack arrives after reset release.

Decomposition:
- Shared package eka_pkg holds:
  - typedef enum logic [1:0] eka_seq_state_t {FETCH, DECODE, DATA, COMMIT};
  - localparam EKA_NOP = 32'h0000_0013.
- One sub-module is natural: eka_bus_watchdog. It contains the counter, the compare to TIMEOUT_CYCLES, and the sticky error flag. Inputs: wait_active, ack, restart. Outputs: timeout pulse, bus_err.

Test Plan:
- Reset low, then high; memory acks fetch at 0x0 with 0x00500093 (addi x1,x0,5) in the same cycle → inst_valid=1 next cycle, data_stall=0, bus_req=0; next fetch at 0x4 one cycle later.
- lw x5,0(x5) with x5=0x100; memory holds 0x100=0xDEADBEEF; ack after 3 wait cycles → bus_addr stays 0x100 throughout DATA; COMMIT has data_stall=0 and mem_rd_data=0xDEADBEEF; x5=0xDEADBEEF afterwards.
- sw x2,8(x0) with x2=0x1234 → one DATA request with bus_wr=1, bus_addr=0x8, bus_wdata=0x1234; exactly one write observed at the memory.
- Before inst_valid: instruction==0x00000013, mem_wr=0, and no spurious Reg_Wr effect on architectural state.
- TIMEOUT_CYCLES=4, memory never acks fetch → bus_err=1 after 4 cycles; NOP committed; next fetch at PC+4; bus_err remains 1.
- reset driven low during DATA wait → bus_req=0 asynchronously, state=FETCH; after release, first bus_req fetches RESET_ADDR.

Source files
------------

// File: rtl/eka_pkg.sv
// Shared types and constants for the Eka core memory sequencer.
package eka_pkg;

    localparam int unsigned BUS_W = 32;
    localparam logic [BUS_W-1:0] EKA_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } eka_seq_state_t;

    // Data-side request captured at decode so it stays stable while the core stalls
    typedef struct packed {
        logic             wr;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
    } eka_data_req_t;

endpackage

// File: rtl/eka_bus_watchdog.sv
// Counts bus wait cycles and aborts a transaction that never gets an ack.
module eka_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_active,
    input  logic ack,
    input  logic restart,
    output logic timeout_c,
    output logic bus_err
);

    localparam bit          ENABLE = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] cnt_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle
    assign timeout_c = ENABLE && wait_active && !ack && (cnt_q == CNT_W'(LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bus_err <= 1'b0;
        end else begin
            if (!ENABLE || restart || ack || !wait_active || timeout_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (timeout_c) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/eka_mem_sequencer.sv
// Time-multiplexes one memory bus between the Eka core's fetch and data ports,
// holding the core in stall until each instruction's bus traffic is done.
module eka_mem_sequencer
    import eka_pkg::*;
#(
    parameter int unsigned      ADDR_WIDTH     = 32,
    parameter logic [BUS_W-1:0] NOP_INST       = EKA_NOP,
    parameter int unsigned      TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [BUS_W-1:0]      instruction,
    output logic                  inst_valid,
    input  logic [BUS_W-1:0]      data_addr,
    input  logic [BUS_W-1:0]      mem_wr_data,
    input  logic                  mem_wr,
    input  logic                  mem_rd,
    output logic [BUS_W-1:0]      mem_rd_data,
    output logic                  data_stall,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [BUS_W-1:0]      bus_addr,
    output logic [BUS_W-1:0]      bus_wdata,
    input  logic                  bus_ack,
    input  logic [BUS_W-1:0]      bus_rdata,
    output logic                  bus_err
);

    eka_seq_state_t state, next_state;
    eka_data_req_t  req_q;
    logic [BUS_W-1:0] inst_q;
    logic [BUS_W-1:0] rdata_q;
    logic bus_req_d;
    logic inst_valid_d;
    logic ack_ok;
    logic timeout_c;
    logic mem_op;

    // Acks only count while a request is actually on the bus
    assign ack_ok = bus_req && bus_ack;
    assign mem_op = mem_rd || mem_wr;

    eka_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (reset),
        .wait_active(bus_req),
        .ack        (bus_ack),
        .restart    (next_state != state),
        .timeout_c  (timeout_c),
        .bus_err    (bus_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next state, plus registered-output values derived from it
    always_comb begin
        next_state   = state;
        bus_req_d    = 1'b0;
        inst_valid_d = 1'b0;
        case (state)
            FETCH:   if (ack_ok || timeout_c) next_state = DECODE;
            DECODE:  next_state = mem_op ? DATA : FETCH;
            DATA:    if (ack_ok || timeout_c) next_state = COMMIT;
            COMMIT:  next_state = FETCH;
            default: next_state = FETCH;
        endcase
        case (next_state)
            FETCH:   bus_req_d = 1'b1;
            DECODE:  inst_valid_d = 1'b1;
            DATA: begin
                bus_req_d    = 1'b1;
                inst_valid_d = 1'b1;
            end
            COMMIT:  inst_valid_d = 1'b1;
            default: bus_req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req    <= 1'b0;
            inst_valid <= 1'b0;
            inst_q     <= NOP_INST;
            rdata_q    <= '0;
            req_q      <= '0;
        end else begin
            bus_req    <= bus_req_d;
            inst_valid <= inst_valid_d;
            case (state)
                FETCH: begin
                    if (ack_ok) begin
                        inst_q <= bus_rdata;
                    end else if (timeout_c) begin
                        inst_q <= NOP_INST;
                    end
                end
                DECODE: begin
                    if (mem_op) begin
                        req_q.wr    <= mem_wr;
                        req_q.addr  <= data_addr;
                        req_q.wdata <= mem_wr_data;
                    end
                end
                DATA: begin
                    if (ack_ok) begin
                        if (!req_q.wr) rdata_q <= bus_rdata;
                    end else if (timeout_c) begin
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
            // The core sees a NOP until the next fetch returns
            if (next_state == FETCH) begin
                inst_q <= NOP_INST;
            end
        end
    end

    assign instruction = inst_q;
    assign mem_rd_data = rdata_q;
    assign bus_wdata   = req_q.wdata;
    assign bus_wr      = (state == DATA) && req_q.wr;
    assign bus_addr    = (state == DATA) ? req_q.addr : BUS_W'(inst_addr);
    // Decode cycle of a load/store is not a commit edge
    assign data_stall  = (state == DATA) || ((state == DECODE) && mem_op);

endmodule

// File: tb/tb_eka_mem_sequencer.sv
// Directed bench: a tiny RV32 core model (addi/lui/lw/sw) driven through the sequencer.
module tb_eka_mem_sequencer;
    import eka_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic        inst_valid;
    logic [31:0] data_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rd_data;
    logic        data_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    eka_mem_sequencer #(
        .ADDR_WIDTH    (32),
        .NOP_INST      (32'h0000_0013),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_addr  (inst_addr),
        .instruction(instruction),
        .inst_valid (inst_valid),
        .data_addr  (data_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_rd_data(mem_rd_data),
        .data_stall (data_stall),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: PC and register file commit on any edge with inst_valid && !data_stall
    logic [31:0] pc;
    logic [31:0] xr [0:31];
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_u;

    always_comb begin
        opc         = instruction[6:0];
        rd          = instruction[11:7];
        rs1         = instruction[19:15];
        rs2         = instruction[24:20];
        imm_i       = {{20{instruction[31]}}, instruction[31:20]};
        imm_s       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        imm_u       = {instruction[31:12], 12'h000};
        mem_rd      = (opc == 7'h03);
        mem_wr      = (opc == 7'h23);
        data_addr   = xr[rs1] + (mem_wr ? imm_s : imm_i);
        mem_wr_data = xr[rs2];
        inst_addr   = pc;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 32'h0;
            for (int i = 0; i < 32; i++) xr[i] <= 32'h0;
        end else if (inst_valid && !data_stall) begin
            pc <= pc + 32'd4;
            if (rd != 5'd0) begin
                case (opc)
                    7'h13:   xr[rd] <= xr[rs1] + imm_i;
                    7'h37:   xr[rd] <= imm_u;
                    7'h03:   xr[rd] <= mem_rd_data;
                    default: ;
                endcase
            end
        end
    end

    // Memory-side write monitor
    always @(posedge clk) begin
        if (bus_req && bus_ack && bus_wr) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= bus_addr;
            last_wr_data <= bus_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch from the FETCH state; ends in the DECODE cycle
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int waits);
        chk1("fetch_req", bus_req, 1'b1);
        chk("fetch_addr", bus_addr, exp_addr);
        chk1("fetch_ivalid", inst_valid, 1'b0);
        chk("fetch_nop", instruction, 32'h0000_0013);
        for (int i = 0; i < waits; i++) tick();
        bus_ack   = 1'b1;
        bus_rdata = word;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        chk1("dec_ivalid", inst_valid, 1'b1);
        chk("dec_inst", instruction, word);
        chk1("dec_req", bus_req, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        repeat (3) tick();
        chk1("rst_req", bus_req, 1'b0);
        chk1("rst_err", bus_err, 1'b0);
        chk1("rst_ivalid", inst_valid, 1'b0);
        chk("rst_inst", instruction, 32'h0000_0013);
        chk1("rst_stall", data_stall, 1'b0);
        chk("rst_rdata", mem_rd_data, 32'h0);

        reset = 1'b1;
        #1;
        chk1("rel_noreq", bus_req, 1'b0);
        tick();

        // addi x1,x0,5 acked in the same cycle
        chk1("pre_memwr", mem_wr, 1'b0);
        chk("pre_x1", xr[1], 32'h0);
        fetch(32'h0, 32'h0050_0093, 0);
        chk1("addi_stall", data_stall, 1'b0);
        chk("addi_x1_before", xr[1], 32'h0);
        tick();
        chk("addi_x1", xr[1], 32'h5);

        // x5 = 0x100, x2 = 0x1234
        fetch(32'h4, 32'h1000_0293, 1);
        tick();
        fetch(32'h8, 32'h0000_1137, 0);
        tick();
        fetch(32'hC, 32'h2341_0113, 2);
        tick();
        chk("x5_init", xr[5], 32'h100);
        chk("x2_init", xr[2], 32'h1234);

        // lw x5,0(x5) with three wait cycles
        fetch(32'h10, 32'h0002_A283, 0);
        chk1("lw_dec_stall", data_stall, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("lw_req", bus_req, 1'b1);
            chk1("lw_wr", bus_wr, 1'b0);
            chk("lw_addr", bus_addr, 32'h100);
            chk1("lw_stall", data_stall, 1'b1);
            tick();
        end
        chk("lw_addr_ack", bus_addr, 32'h100);
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        chk1("lw_commit_stall", data_stall, 1'b0);
        chk1("lw_commit_ivalid", inst_valid, 1'b1);
        chk1("lw_commit_req", bus_req, 1'b0);
        chk("lw_rdata", mem_rd_data, 32'hDEAD_BEEF);
        chk1("lw_no_err", bus_err, 1'b0);
        tick();
        chk("lw_x5", xr[5], 32'hDEAD_BEEF);

        // sw x2,8(x0), zero-wait
        fetch(32'h14, 32'h0020_2423, 0);
        chk1("sw_dec_stall", data_stall, 1'b1);
        tick();
        chk1("sw_req", bus_req, 1'b1);
        chk1("sw_wr", bus_wr, 1'b1);
        chk("sw_addr", bus_addr, 32'h8);
        chk("sw_wdata", bus_wdata, 32'h1234);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk1("sw_commit_stall", data_stall, 1'b0);
        chk1("sw_commit_wr", bus_wr, 1'b0);
        chk("sw_count", 32'(wr_count), 32'd1);
        chk("sw_mem_addr", last_wr_addr, 32'h8);
        chk("sw_mem_data", last_wr_data, 32'h1234);
        tick();

        // Fetch at 0x18 never acked: watchdog fires on the fourth wait cycle
        chk("to_addr", bus_addr, 32'h18);
        chk1("to_err0", bus_err, 1'b0);
        tick();
        tick();
        tick();
        chk1("to_req4", bus_req, 1'b1);
        chk1("to_err4", bus_err, 1'b0);
        tick();
        chk1("to_err", bus_err, 1'b1);
        chk1("to_ivalid", inst_valid, 1'b1);
        chk("to_nop", instruction, 32'h0000_0013);
        chk1("to_stall", data_stall, 1'b0);
        tick();
        chk("to_next_addr", bus_addr, 32'h1C);
        chk1("to_err_sticky", bus_err, 1'b1);
        chk("to_x5_kept", xr[5], 32'hDEAD_BEEF);

        // Reset asserted while a store waits in DATA
        fetch(32'h1C, 32'h0020_2423, 0);
        tick();
        chk1("rd_req", bus_req, 1'b1);
        chk1("rd_wr", bus_wr, 1'b1);
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk1("arst_req", bus_req, 1'b0);
        chk("arst_state", 32'(dut.state), 32'(FETCH));
        chk1("arst_err", bus_err, 1'b0);
        chk("arst_wrcount", 32'(wr_count), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk1("arst_rel_noreq", bus_req, 1'b0);
        tick();
        chk1("arst_first_req", bus_req, 1'b1);
        chk("arst_first_addr", bus_addr, 32'h0);
        chk1("arst_first_wr", bus_wr, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
